scan_mux_n_1: RTL and testbench
===============================

SCAN_MUX_N_1 -- requirements
Module: SCAN_MUX_N_1

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per channel.
REQ-002 Parameter CHANNELS, default 32, number of input channels (2..256).
REQ-003 Parameter SEL_WIDTH, default 5, width of channel index; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Clock_In  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset_In  input  1  reset, asynchronous, active-high.
REQ-006 Enable_In  input  1  permits new samples to load.
REQ-007 Mode_In  input  1  0 = direct select, 1 = auto-scan.
REQ-008 Select_In  input  SEL_WIDTH  channel index in direct mode.
REQ-009 Data_In  input  CHANNELS*DATA_WIDTH  packed channels; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Channel_Mask_In  input  CHANNELS  scan mode: 1 = channel included.
REQ-011 Out_Ready_In  input  1  downstream accepts the current output.
REQ-012 MUX_Data_Out  output  DATA_WIDTH  registered selected sample.
REQ-013 MUX_Channel_Out  output  SEL_WIDTH  index of the sample on MUX_Data_Out.
REQ-014 MUX_Valid_Out  output  1  output sample valid.
REQ-015 Scan_Wrap_Out  output  1  one-cycle pulse: scan sweep restarted.
REQ-016 Sel_Error_Out  output  1  one-cycle pulse: direct Select_In >= CHANNELS.

Function
REQ-017 Transfer SHALL occur on a rising edge where MUX_Valid_Out=1 and Out_Ready_In=1.
REQ-018 Load condition: Enable_In=1 and (MUX_Valid_Out=0 or transfer) and a candidate channel exists; on load, data, index and MUX_Valid_Out=1 register on that edge (1-cycle latency).
REQ-019 If no load occurs on a transfer edge, MUX_Valid_Out SHALL clear; if MUX_Valid_Out=1 and Out_Ready_In=0, all outputs SHALL hold (no data change while stalled).
REQ-020 Direct mode candidate: Select_In if < CHANNELS; otherwise no load and Sel_Error_Out pulses on the edge the load would have occurred.
REQ-021 Scan mode candidate: first channel with mask bit 1 searching cyclically from Scan_Ptr; after a load Scan_Ptr = (candidate+1) mod CHANNELS.
REQ-022 Scan_Wrap_Out SHALL pulse on a scan load whose search passed from CHANNELS-1 to 0, or whose candidate is less than Scan_Ptr.
REQ-023 Channel_Mask_In all zero: no load, Scan_Ptr holds, no wrap pulse.
REQ-024 State machine IDLE/RUN/STALL: IDLE = MUX_Valid_Out 0; RUN = valid and accepted or loading; STALL = valid and Out_Ready_In=0; IDLE->RUN on load, RUN->STALL on load without ready, STALL->RUN on transfer with load, STALL/RUN->IDLE on transfer without load.
REQ-025 Enable_In=0 SHALL block loads only; a pending valid sample SHALL remain until transferred.
REQ-026 Mode_In change takes effect on the next load; Scan_Ptr retained across direct-mode periods.

Reset
REQ-027 Reset_In=1 SHALL immediately force MUX_Data_Out=0, MUX_Channel_Out=0, MUX_Valid_Out=0, Scan_Wrap_Out=0, Sel_Error_Out=0, Scan_Ptr=0, state IDLE.
REQ-028 Reset asserted mid-stall SHALL discard the pending sample; first load after release uses Scan_Ptr=0.

Configuration
REQ-029 Macro SCAN_MUX_TRISTATE_OUT_EN defined: MUX_Data_Out SHALL be high-impedance whenever Enable_In=0 (internal register unaffected); undefined: MUX_Data_Out always drives the register.

Verification
REQ-030 Direct: CHANNELS=32, Select_In=5, channel 5=8'hA5, ready=1 -> next edge MUX_Data_Out=A5, Channel=5, Valid=1.
REQ-031 Stall: valid sample 8'h3C, ready=0 for 4 cycles while Data_In changes -> outputs hold 3C; ready=1 -> transfer, new sample next edge.
REQ-032 Scan: mask=32'h0000_0111, ready=1 -> channels 0,4,8,0 in successive cycles; Scan_Wrap_Out pulses with the second channel-0 load.
REQ-033 Errors: CHANNELS=20, direct Select_In=25 -> Sel_Error_Out=1 one cycle, Valid stays 0; scan mask=0 -> Valid 0, Scan_Ptr unchanged.
REQ-034 Reset mid-stall: Valid=1, ready=0, assert Reset_In asynchronously -> all outputs 0 before next edge; after release scan restarts at channel 0.
REQ-035 Macro defined, Enable_In=0 -> MUX_Data_Out=Z; Enable_In=1 -> registered value reappears.

Source files
------------

// File: rtl/scan_mux_n_1.sv
// Registered N:1 channel multiplexer with direct-select and masked auto-scan modes, ready/valid output.
// Optional build macro SCAN_MUX_TRISTATE_OUT_EN: MUX_Data_Out floats whenever Enable_In is low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no valid sample on the outputs
// RUN   | valid sample presented, freshly loaded or being accepted
// STALL | valid sample held because downstream was not ready last edge
module scan_mux_n_1 #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic                           Clock_In,
    input  logic                           Reset_In,
    input  logic                           Enable_In,
    input  logic                           Mode_In,
    input  logic [SEL_WIDTH-1:0]           Select_In,
    input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
    input  logic [CHANNELS-1:0]            Channel_Mask_In,
    input  logic                           Out_Ready_In,
    output logic [DATA_WIDTH-1:0]          MUX_Data_Out,
    output logic [SEL_WIDTH-1:0]           MUX_Channel_Out,
    output logic                           MUX_Valid_Out,
    output logic                           Scan_Wrap_Out,
    output logic                           Sel_Error_Out
);

    localparam logic [SEL_WIDTH:0] CH_EXT = (SEL_WIDTH+1)'(CHANNELS);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t                  state, state_next;
    logic                    valid;
    logic                    transfer, can_accept;
    logic [SEL_WIDTH-1:0]    scan_ptr;
    logic [SEL_WIDTH-1:0]    scan_cand;
    logic                    scan_found, scan_wrap;
    logic                    sel_ok;
    logic [SEL_WIDTH-1:0]    load_cand;
    logic                    cand_ok, load;
    logic [SEL_WIDTH-1:0]    ptr_after_load;
    logic [DATA_WIDTH-1:0]   data_sel;
    logic [DATA_WIDTH-1:0]   data_q;

    assign transfer   = valid & Out_Ready_In;
    assign can_accept = ~valid | transfer;
    assign sel_ok     = {1'b0, Select_In} < CH_EXT;

    // Cyclic search from scan_ptr; descending loop so the lowest offset wins.
    always_comb begin
        logic [SEL_WIDTH:0] pos;
        logic               wrapped;
        scan_found = 1'b0;
        scan_cand  = '0;
        scan_wrap  = 1'b0;
        pos        = '0;
        wrapped    = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            pos     = {1'b0, scan_ptr} + (SEL_WIDTH+1)'(i);
            wrapped = pos >= CH_EXT;
            if (wrapped) pos = pos - CH_EXT;
            if (Channel_Mask_In[pos[SEL_WIDTH-1:0]]) begin
                scan_found = 1'b1;
                scan_cand  = pos[SEL_WIDTH-1:0];
                scan_wrap  = wrapped;
            end
        end
    end

    always_comb begin
        logic [SEL_WIDTH:0] nxt;
        nxt            = {1'b0, scan_cand} + (SEL_WIDTH+1)'(1);
        ptr_after_load = (nxt == CH_EXT) ? '0 : nxt[SEL_WIDTH-1:0];
    end

    assign load_cand = Mode_In ? scan_cand : Select_In;
    assign cand_ok   = Mode_In ? scan_found : sel_ok;
    assign load      = Enable_In & can_accept & cand_ok;
    assign data_sel  = Data_In[load_cand*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (load) state_next = RUN;
            RUN, STALL: begin
                if (Out_Ready_In) state_next = load ? RUN : IDLE;
                else              state_next = STALL;
            end
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        valid         = (state != IDLE);
        MUX_Valid_Out = valid;
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            data_q          <= '0;
            MUX_Channel_Out <= '0;
            scan_ptr        <= '0;
            Scan_Wrap_Out   <= 1'b0;
            Sel_Error_Out   <= 1'b0;
        end else begin
            if (load) begin
                data_q          <= data_sel;
                MUX_Channel_Out <= load_cand;
                if (Mode_In) scan_ptr <= ptr_after_load;
            end
            Scan_Wrap_Out <= load & Mode_In & scan_wrap;
            Sel_Error_Out <= Enable_In & can_accept & ~Mode_In & ~sel_ok;
        end
    end

`ifdef SCAN_MUX_TRISTATE_OUT_EN
    assign MUX_Data_Out = Enable_In ? data_q : {DATA_WIDTH{1'bz}};
`else
    assign MUX_Data_Out = data_q;
`endif

endmodule

// File: tb/tb_scan_mux_n_1.sv
// Self-checking bench for scan_mux_n_1 (20 channels) against a cycle-level behavioural model.
module tb_scan_mux_n_1;

    localparam int DW = 8;
    localparam int CH = 20;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [CH*DW-1:0]  data_in;
    logic [CH-1:0]     mask;
    logic              rdy;
    logic [DW-1:0]     mux_data;
    logic [SW-1:0]     mux_ch;
    logic              mux_valid;
    logic              scan_wrap;
    logic              sel_err;

    logic [DW-1:0]     chan [CH];

    int n_checks;
    int n_errors;

    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;
    bit            m_valid;
    bit            m_wrap;
    bit            m_err;

    int scan_exp [4] = '{0, 4, 8, 0};

    scan_mux_n_1 #(.DATA_WIDTH(DW), .CHANNELS(CH), .SEL_WIDTH(SW)) dut (
        .Clock_In        (clk),
        .Reset_In        (rst),
        .Enable_In       (en),
        .Mode_In         (mode),
        .Select_In       (sel),
        .Data_In         (data_in),
        .Channel_Mask_In (mask),
        .Out_Ready_In    (rdy),
        .MUX_Data_Out    (mux_data),
        .MUX_Channel_Out (mux_ch),
        .MUX_Valid_Out   (mux_valid),
        .Scan_Wrap_Out   (scan_wrap),
        .Sel_Error_Out   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < CH; i++) data_in[i*DW +: DW] = chan[i];
    endtask

    task automatic model_reset();
        m_data = '0; m_ch = 0; m_ptr = 0; m_valid = 0; m_wrap = 0; m_err = 0;
    endtask

    // One rising edge of the reference behaviour, using the inputs currently applied.
    task automatic model_step();
        bit transfer, can, cand_ok, wr, sel_in_range;
        int cand, c;
        transfer     = m_valid && rdy;
        can          = !m_valid || transfer;
        sel_in_range = int'(sel) < CH;
        cand_ok = 0; cand = 0; wr = 0;
        if (!mode) begin
            cand_ok = sel_in_range;
            cand    = int'(sel);
        end else begin
            for (int off = 0; off < CH; off++) begin
                c = (m_ptr + off) % CH;
                if (!cand_ok && mask[c]) begin
                    cand_ok = 1; cand = c; wr = (m_ptr + off) >= CH;
                end
            end
        end
        m_err  = en && can && !mode && !sel_in_range;
        m_wrap = en && can && mode && cand_ok && wr;
        if (en && can && cand_ok) begin
            m_data  = chan[cand];
            m_ch    = cand;
            m_valid = 1;
            if (mode) m_ptr = (cand + 1) % CH;
        end else if (transfer) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] exp_d;
        exp_d = m_data;
`ifdef SCAN_MUX_TRISTATE_OUT_EN
        if (!en) exp_d = {DW{1'bz}};
`endif
        check({tag, "_data"},  32'(mux_data),  32'(exp_d));
        check({tag, "_chan"},  32'(mux_ch),    32'(m_ch));
        check({tag, "_valid"}, 32'(mux_valid), 32'(m_valid));
        check({tag, "_wrap"},  32'(scan_wrap), 32'(m_wrap));
        check({tag, "_err"},   32'(sel_err),   32'(m_err));
    endtask

    task automatic cycle(input string tag);
        pack();
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic randomize_chans();
        foreach (chan[i]) chan[i] = DW'($urandom);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; mask = '0; rdy = 1'b0;
        foreach (chan[i]) chan[i] = '0;
        pack();
        model_reset();
        #2;
        check_outputs("reset");
        check("reset_valid_const", 32'(mux_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // direct select of channel 5
        en = 1'b1; mode = 1'b0; sel = 5'd5; rdy = 1'b1; chan[5] = 8'hA5;
        cycle("direct");
        check("direct_a5", 32'(mux_data), 32'h0000_00A5);
        check("direct_ch5", 32'(mux_ch), 32'd5);

        // stall holds 3C while inputs churn
        chan[5] = 8'h3C;
        cycle("load3c");
        rdy = 1'b0;
        repeat (4) begin
            randomize_chans();
            cycle("stall");
            check("stall_hold", 32'(mux_data), 32'h0000_003C);
        end
        rdy = 1'b1; chan[5] = 8'h77;
        cycle("release");
        check("release_new", 32'(mux_data), 32'h0000_0077);

        // scan sweep 0,4,8,0 with wrap on the second channel 0
        mode = 1'b1; mask = 20'h00111;
        for (int k = 0; k < 4; k++) begin
            cycle("scan");
            check("scan_seq", 32'(mux_ch), 32'(scan_exp[k]));
            check("scan_wrap_seq", 32'(scan_wrap), (k == 3) ? 32'd1 : 32'd0);
        end

        // out-of-range select and empty mask
        mode = 1'b0; sel = 5'd25;
        cycle("selerr");
        check("selerr_pulse", 32'(sel_err), 32'd1);
        check("selerr_novalid", 32'(mux_valid), 32'd0);
        cycle("selerr2");
        mode = 1'b1; mask = '0;
        cycle("mask0");
        check("mask0_novalid", 32'(mux_valid), 32'd0);
        mask = 20'h00111;
        cycle("ptr_kept");
        check("ptr_kept_ch4", 32'(mux_ch), 32'd4);

        // enable low blocks loads but keeps the pending sample
        en = 1'b0; rdy = 1'b0;
        cycle("en0_hold");
        check("en0_hold_valid", 32'(mux_valid), 32'd1);
        rdy = 1'b1;
        cycle("en0_drain");
        check("en0_drain_valid", 32'(mux_valid), 32'd0);
        en = 1'b1;

        // asynchronous reset while stalled
        mask = 20'h00100;
        cycle("pre_stall");
        rdy = 1'b0;
        cycle("stall2");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst_valid", 32'(mux_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mask = '1; rdy = 1'b1;
        cycle("post_rst");
        check("post_rst_ch0", 32'(mux_ch), 32'd0);

        // randomized traffic
        repeat (400) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = 1'($urandom);
            sel  = SW'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: mask = '0;
                1: begin mask = '0; mask[$urandom_range(0, CH-1)] = 1'b1; end
                2: mask = CH'($urandom);
                default: mask = CH'($urandom) & CH'($urandom);
            endcase
            rdy = ($urandom_range(0, 2) != 0);
            randomize_chans();
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
